serial_tx_drain: RTL and testbench

Downstream consumer of the serial port FIFO. It watches the FIFO empty flag, pops one byte at a time with a single-cycle read strobe, and shifts each byte out on a single asynchronous serial line: start bit, 8 data bits LSB first, one stop bit. It runs in the same clock domain as the FIFO and drains it continuously while enabled.

---
 rtl/serial_pkg.sv | 23 ++
 rtl/serial_baud_gen.sv | 35 +++
 rtl/serial_tx_drain.sv | 129 ++++++++++++
 tb/tb_serial_tx_drain.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit path.
package serial_pkg;

  localparam int DATA_BITS = 8;

  // Added to the XOR of the data bits: 1'b0 gives even parity, 1'b1 odd.
  localparam logic PARITY_ODD = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

endpackage

// File: rtl/serial_baud_gen.sv
// Bit-cycle counter: wraps every CLKS_PER_BIT cycles and restarts from 0 on request.
module serial_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end,
  output logic bit_end_next
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end      = (cnt_q == LAST);
  assign bit_end_next = (cnt_d == LAST);

endmodule

// File: rtl/serial_tx_drain.sv
// Pops bytes from the serial FIFO and shifts them out as 8N1 frames.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx_drain
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  input  logic                 tx_en,
  output logic                 tx_line,
  output logic                 busy,
  output logic                 byte_done
);

  localparam int IW = $clog2(DATA_BITS);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 tx_line_q, tx_line_d;
  logic                 rd_en_q, rd_en_d;
  logic                 done_q, done_d;
  logic                 bit_end, bit_end_next, restart;
`ifdef SERIAL_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Every state change restarts the bit timer so each state sees a full bit period.
  assign restart = (state_d != state_q);

  serial_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (restart),
    .bit_end     (bit_end),
    .bit_end_next(bit_end_next)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (tx_en && !fifo_empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD:  state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && (bit_idx_q == IW'(DATA_BITS - 1))) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) state_d = (tx_en && !fifo_empty) ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered without lag.
  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    if (state_q == LOAD) begin
      shift_d = fifo_rd_data;
    end else if ((state_q == DATA) && bit_end) begin
      shift_d = shift_q >> 1;
    end
    if (state_q != DATA) begin
      bit_idx_d = '0;
    end else if (bit_end) begin
      bit_idx_d = bit_idx_q + 1'b1;
    end
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
    if (state_q == LOAD) parity_d = calc_parity(fifo_rd_data);
`endif
    rd_en_d   = (state_d == FETCH);
    done_d    = (state_d == STOP) && bit_end_next;
    tx_line_d = 1'b1;
    case (state_d)
      START:   tx_line_d = 1'b0;
      DATA:    tx_line_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  tx_line_d = parity_q;
`endif
      default: tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_line_q <= 1'b1;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_line_q <= tx_line_d;
      rd_en_q   <= rd_en_d;
      done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_line    = tx_line_q;
  assign fifo_rd_en = rd_en_q;
  assign byte_done  = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_tx_drain.sv
// Bench for serial_tx_drain: FIFO model, UART-style frame decoder and scenario tasks.
module tb_serial_tx_drain;

  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx_en = 1'b0;
  logic       tx_line;
  logic       busy;
  logic       byte_done;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] fq[$];
  int rdCount = 0;
  int rdWhileEmpty = 0;

  logic [7:0] rxQ[$];
  int startQ[$];
  int endQ[$];
  int frameErr = 0;
  int cyc = 0;
  logic monActive = 1'b0;
  int monPos = 0;
  int monStart = 0;
  logic [63:0] monSamp = '0;
  logic [63:0] monDone = '0;

  serial_tx_drain #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .tx_en       (tx_en),
    .tx_line     (tx_line),
    .busy        (busy),
    .byte_done   (byte_done)
  );

  always #5 clk = ~clk;

  // Ideal expected waveform: each frame bit held for CPB cycles.
  function automatic logic [63:0] exp_wave(input logic [7:0] b);
    logic [NBITS-1:0] fb;
    logic [63:0] w;
    fb = '0;
    for (int j = 0; j < 8; j++) fb[1+j] = b[j];
`ifdef SERIAL_TX_PARITY_EN
    fb[9] = ^b;
`endif
    fb[NBITS-1] = 1'b1;
    w = '0;
    for (int i = 0; i < FLEN; i++) w[i] = fb[i/CPB];
    return w;
  endfunction

  function automatic int frame_errs(input logic [63:0] s, input logic [63:0] dn, output logic [7:0] d);
    int e;
    logic [NBITS-1:0] fb;
    e = 0;
    for (int k = 0; k < NBITS; k++) begin
      fb[k] = s[k*CPB];
      for (int c = 1; c < CPB; c++) if (s[k*CPB+c] !== fb[k]) e++;
    end
    if (fb[0] !== 1'b0) e++;
    if (fb[NBITS-1] !== 1'b1) e++;
    for (int j = 0; j < 8; j++) d[j] = fb[1+j];
`ifdef SERIAL_TX_PARITY_EN
    if (fb[9] !== ^d) e++;
`endif
    if (dn !== (64'd1 << (FLEN-1))) e++;
    return e;
  endfunction

  // FIFO model: read data appears in the cycle after the strobe.
  always @(negedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      rdCount++;
      if (fq.size() == 0) rdWhileEmpty++;
      else fifo_rd_data = fq.pop_front();
    end
    fifo_empty = (fq.size() == 0);
  end

  // Frame decoder: a frame starts at the first low sample and spans FLEN cycles.
  always @(negedge clk) begin
    logic [7:0] d;
    cyc++;
    if (rst_n !== 1'b1) begin
      monActive = 1'b0;
    end else begin
      if (!monActive && (tx_line === 1'b0)) begin
        monActive = 1'b1;
        monPos = 0;
        monStart = cyc;
        monSamp = '0;
        monDone = '0;
      end
      if (monActive) begin
        monSamp[monPos] = tx_line;
        monDone[monPos] = byte_done;
        monPos++;
        if (monPos == FLEN) begin
          monActive = 1'b0;
          frameErr += frame_errs(monSamp, monDone, d);
          rxQ.push_back(d);
          startQ.push_back(monStart);
          endQ.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk);
    #2;
    fq.push_back(b);
  endtask

  task automatic wait_tx_low(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_line === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int target, input int limit);
    for (int i = 0; (i < limit) && (rxQ.size() < target); i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tx_en = 1'b1;
    fq.push_back(8'hA5);
    repeat (10) @(negedge clk);
    testsRun++;
    if (tx_line !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_tx_line: got %b want 1", tx_line); end
    testsRun++;
    if (fifo_rd_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    testsRun++;
    if (byte_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_byte_done: got %b want 0", byte_done); end
    testsRun++;
    if (rdCount !== 0) begin testsFailed++; $display("[TB] FAIL reset_no_read: got %0d reads want 0", rdCount); end
    tx_en = 1'b0;
    fq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    testsRun++;
    if ((busy !== 1'b0) || (tx_line !== 1'b1)) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_idle: got busy=%b tx=%b want busy=0 tx=1", busy, tx_line);
    end
  endtask

  task automatic test_single_frame(input logic [7:0] b);
    logic [63:0] actW, actD, actB, expW;
    int rdB;
    rdB = rdCount;
    actW = '0; actD = '0; actB = '0;
    expW = exp_wave(b);
    push_byte(b);
    @(negedge clk);
    tx_en = 1'b1;
    @(negedge clk);
    testsRun++;
    if ((fifo_rd_en !== 1'b1) || (busy !== 1'b1)) begin
      testsFailed++;
      $display("[TB] FAIL single_%h_fetch: got rd_en=%b busy=%b want 1 1", b, fifo_rd_en, busy);
    end
    @(negedge clk);
    testsRun++;
    if ((fifo_rd_en !== 1'b0) || (tx_line !== 1'b1)) begin
      testsFailed++;
      $display("[TB] FAIL single_%h_load: got rd_en=%b tx=%b want 0 1", b, fifo_rd_en, tx_line);
    end
    for (int i = 0; i < FLEN; i++) begin
      @(negedge clk);
      actW[i] = tx_line;
      actD[i] = byte_done;
      actB[i] = busy;
    end
    @(negedge clk);
    testsRun++;
    if (actW !== expW) begin testsFailed++; $display("[TB] FAIL single_%h_wave: got %h want %h", b, actW, expW); end
    testsRun++;
    if (actD !== (64'd1 << (FLEN-1))) begin
      testsFailed++;
      $display("[TB] FAIL single_%h_byte_done: got %h want %h", b, actD, 64'd1 << (FLEN-1));
    end
    testsRun++;
    if (actB !== ((64'd1 << FLEN) - 64'd1)) begin
      testsFailed++;
      $display("[TB] FAIL single_%h_busy_wave: got %h want %h", b, actB, (64'd1 << FLEN) - 64'd1);
    end
    testsRun++;
    if ((busy !== 1'b0) || (tx_line !== 1'b1)) begin
      testsFailed++;
      $display("[TB] FAIL single_%h_idle_after: got busy=%b tx=%b want 0 1", b, busy, tx_line);
    end
    testsRun++;
    if (rdCount - rdB !== 1) begin testsFailed++; $display("[TB] FAIL single_%h_reads: got %0d want 1", b, rdCount - rdB); end
    tx_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    string msg;
    int rxB, rdB, errB, badGaps;
    msg = "hello wor";
    rxB = rxQ.size(); rdB = rdCount; errB = frameErr; badGaps = 0;
    @(posedge clk);
    #2;
    for (int i = 0; i < msg.len(); i++) fq.push_back(msg[i]);
    tx_en = 1'b1;
    wait_rx(rxB + 9, 9 * (FLEN + 2) + 40);
    testsRun++;
    if (rxQ.size() - rxB !== 9) begin testsFailed++; $display("[TB] FAIL b2b_count: got %0d frames want 9", rxQ.size() - rxB); end
    for (int i = 0; (i < 9) && (rxB + i < rxQ.size()); i++) begin
      testsRun++;
      if (rxQ[rxB+i] !== msg[i]) begin
        testsFailed++;
        $display("[TB] FAIL b2b_byte%0d: got %h want %h", i, rxQ[rxB+i], msg[i]);
      end
    end
    for (int i = rxB + 1; i < rxQ.size(); i++) if (startQ[i] - endQ[i-1] - 1 != 2) badGaps++;
    testsRun++;
    if (badGaps !== 0) begin testsFailed++; $display("[TB] FAIL b2b_gap: got %0d gaps not 2 cycles want 0", badGaps); end
    testsRun++;
    if (rdCount - rdB !== 9) begin testsFailed++; $display("[TB] FAIL b2b_reads: got %0d want 9", rdCount - rdB); end
    testsRun++;
    if (frameErr - errB !== 0) begin testsFailed++; $display("[TB] FAIL b2b_frame_errs: got %0d want 0", frameErr - errB); end
    repeat (4) @(negedge clk);
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_idle: got busy=%b want 0", busy); end
    tx_en = 1'b0;
  endtask

  task automatic test_tx_en_drop;
    logic [7:0] b[3];
    int rxB, rdB;
    bit ok, seen;
    rxB = rxQ.size(); rdB = rdCount; seen = 1'b0;
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) fq.push_back(b[i]);
    tx_en = 1'b1;
    wait_tx_low(20, ok);
    testsRun++;
    if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL drop_start: got no start bit want start within 20 cycles"); end
    repeat (18) @(negedge clk);
    tx_en = 1'b0;
    for (int i = 0; (i < FLEN + 10) && !seen; i++) begin
      @(negedge clk);
      if (byte_done === 1'b1) seen = 1'b1;
    end
    testsRun++;
    if (seen !== 1'b1) begin testsFailed++; $display("[TB] FAIL drop_byte_done: got no pulse want one"); end
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL drop_busy_fall: got %b want 0", busy); end
    repeat (30) @(negedge clk);
    testsRun++;
    if ((rdCount - rdB !== 1) || (fq.size() !== 2)) begin
      testsFailed++;
      $display("[TB] FAIL drop_reads: got %0d reads, %0d left want 1 reads, 2 left", rdCount - rdB, fq.size());
    end
    testsRun++;
    if ((rxQ.size() - rxB !== 1) || (rxQ[rxQ.size()-1] !== b[0])) begin
      testsFailed++;
      $display("[TB] FAIL drop_frame: got %0d frames last %h want 1 frame %h", rxQ.size() - rxB, rxQ[rxQ.size()-1], b[0]);
    end
    fq.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b1, b2;
    int rxB, rdB, errB;
    bit ok;
    b1 = 8'($urandom) & 8'hF7;
    b2 = 8'($urandom);
    rxB = rxQ.size(); rdB = rdCount; errB = frameErr;
    @(posedge clk);
    #2;
    fq.push_back(b1);
    fq.push_back(b2);
    tx_en = 1'b1;
    wait_tx_low(20, ok);
    testsRun++;
    if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_start: got no start bit want start"); end
    repeat (17) @(negedge clk);
    testsRun++;
    if (tx_line !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_bit3: got %b want 0", tx_line); end
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ((tx_line !== 1'b1) || (busy !== 1'b0) || (fifo_rd_en !== 1'b0) || (byte_done !== 1'b0)) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_async: got tx=%b busy=%b rd=%b done=%b want 1 0 0 0", tx_line, busy, fifo_rd_en, byte_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_rx(rxB + 1, 2 * FLEN + 20);
    testsRun++;
    if ((rxQ.size() - rxB !== 1) || (rxQ[rxQ.size()-1] !== b2)) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_next: got %0d frames last %h want 1 frame %h", rxQ.size() - rxB, rxQ[rxQ.size()-1], b2);
    end
    testsRun++;
    if (frameErr - errB !== 0) begin testsFailed++; $display("[TB] FAIL rstmid_frame_errs: got %0d want 0", frameErr - errB); end
    testsRun++;
    if (rdCount - rdB !== 2) begin testsFailed++; $display("[TB] FAIL rstmid_reads: got %0d want 2", rdCount - rdB); end
    tx_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random;
    logic [7:0] expQ[$];
    int rxB, rdB, errB, n, bad;
    errB = frameErr;
    for (int r = 0; r < 4; r++) begin
      rxB = rxQ.size(); rdB = rdCount; bad = 0;
      expQ.delete();
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        expQ.push_back(8'($urandom));
        push_byte(expQ[k]);
        tx_en = 1'b1;
        repeat ($urandom_range(0, 50)) @(negedge clk);
      end
      wait_rx(rxB + n, n * (FLEN + 3) + 60);
      testsRun++;
      if (rxQ.size() - rxB !== n) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_count: got %0d frames want %0d", r, rxQ.size() - rxB, n);
      end
      for (int k = 0; (k < n) && (rxB + k < rxQ.size()); k++) if (rxQ[rxB+k] !== expQ[k]) bad++;
      testsRun++;
      if (bad !== 0) begin testsFailed++; $display("[TB] FAIL rand%0d_data: got %0d wrong bytes want 0", r, bad); end
      testsRun++;
      if (rdCount - rdB !== n) begin testsFailed++; $display("[TB] FAIL rand%0d_reads: got %0d want %0d", r, rdCount - rdB, n); end
    end
    tx_en = 1'b0;
    testsRun++;
    if (frameErr - errB !== 0) begin testsFailed++; $display("[TB] FAIL rand_frame_errs: got %0d want 0", frameErr - errB); end
    testsRun++;
    if (rdWhileEmpty !== 0) begin testsFailed++; $display("[TB] FAIL read_while_empty: got %0d want 0", rdWhileEmpty); end
  endtask

  initial begin
    test_reset();
    test_single_frame(8'h68);
    test_back_to_back();
    test_tx_en_drop();
    test_reset_midframe();
`ifdef SERIAL_TX_PARITY_EN
    test_single_frame(8'h6C);
    test_single_frame(8'h64);
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
